dlx_decode_stage: RTL and testbench
===================================

DLX_DECODE_STAGE -- requirements
Module: dlx_decode_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32: register and operand width; legal values 32 and 64.
REQ-002 SHALL provide parameter LOAD_LAT, default 1: load-use bubble count; legal range 1..3.
REQ-003 SHALL provide parameter PC_W, default 32: program counter width.
REQ-004 SHALL use a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-005 Ports SHALL be as follows:
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `id_valid` in 1: instruction present.
- `id_ready` out 1: stage accepts.
- `id_instr` in [0:31]: DLX instruction, bit 0 is the MSB.
- `id_pc` in PC_W: PC of the instruction.
- `rs1_val` in XLEN: register-file read of rs1.
- `ex_valid` out 1: decoded bundle present.
- `ex_ready` in 1: EX accepts.
- `ex_regwr` out 1: register write enable.
- `ex_regdst` out 5: destination register.
- `ex_extop` out 1: sign extend (1) or zero extend (0).
- `ex_alusrc` out 1: ALU B operand is a register (1) or the immediate (0).
- `ex_aluop` out 4: ALU operation.
- `ex_memwr` out 1: memory write.
- `ex_memtoreg` out 1: load result to register.
- `ex_imm` out XLEN: extended immediate.
- `ex_illegal` out 1: unknown opcode/func.
- `redirect_valid` out 1: taken-control-flow pulse.
- `redirect_pc` out PC_W: redirect target.

Function
REQ-006 Fields SHALL decode as follows:
- opcode [0:5], rs1 [6:10].
- I-type: rd [11:15], imm [16:31].
- R-type (opcode 0): rs2 [11:15], rd [16:20], func [26:31].
- J-type: offset [6:31].
REQ-007 ALU codes SHALL be: and 0000, or 0001, addu 0010, add 0011, sub 0100, slt 0101, subu 0111, sll 1001, xor 1011.
REQ-008 Decode rules SHALL be:
- add/addi/lw/lb/lbu/sw/sb use aluop 0011; addui uses 0010; subi uses 0100; subui uses 0111.
- R-type func 0x20/0x21/0x18/0x19/0x26/0x28 use add/addu/sub/subu/xor/slt respectively.
REQ-009 ex_extop SHALL be 1 for addi, subi, all loads, stores and branches; 0 otherwise; ex_imm SHALL be imm[16:31] extended to XLEN accordingly.
REQ-010 ex_regwr SHALL be 1 for R-type ALU ops, I-type ALU ops, loads, lhi and jal; 0 for stores, branches, j, jr, nop (func 0x15) and illegal instructions.
REQ-011 ex_regdst SHALL be 31 for jal, R-type rd for R-type instructions, and I-type rd otherwise.
REQ-012 ex_memtoreg SHALL be 1 for lw, lb and lbu; ex_memwr SHALL be 1 for sw and sb.
REQ-013 An unrecognised opcode or func SHALL set ex_illegal=1 and force regwr, memwr and redirect to 0.
REQ-014 Handshake rules:
- An instruction SHALL be accepted when id_valid && id_ready.
- The output register SHALL load when !ex_valid || ex_ready.
- id_ready SHALL be (!ex_valid || ex_ready) && !stall.
REQ-015 The bundle SHALL hold stable while ex_valid && !ex_ready.
REQ-016 Latency SHALL be one cycle from acceptance to ex_valid.
REQ-017 Load-use interlock:
- Trigger: the last accepted instruction was a load with rd != 0, and the instruction at id_instr reads that rd (rs1, or rs2 for R-type/stores).
- Effect: stall SHALL assert for exactly LOAD_LAT cycles, counted by a down-counter.
- A bubble (ex_valid=0) SHALL be issued during each stall cycle in which EX accepts.
REQ-018 Pending-load tracking SHALL age with issued cycles, so an instruction arriving after LOAD_LAT intervening issues or bubbles SHALL not stall.
REQ-019 Control-flow redirects SHALL be evaluated in the acceptance cycle, combinationally, for one cycle:
- beqz: taken when rs1_val == 0; target id_pc+4+sext(imm).
- bnez: taken when rs1_val != 0; target id_pc+4+sext(imm).
- j/jal: target id_pc+4+sext(offset).
- jr (0x12) / jalr (0x13): target rs1_val[PC_W-1:0].
REQ-020 A branch or jr whose rs1 hits the pending load SHALL stall first; redirect SHALL use the post-stall rs1_val.
REQ-021 Target addition SHALL wrap modulo 2^PC_W.
REQ-022 A stall and ex_ready=0 in the same cycle SHALL hold both the counter and the output register (counter decrements only on cycles EX accepts a bubble).

Reset
REQ-023 On rst_n=0, asynchronously:
- ex_valid=0, redirect_valid=0, stall counter=0, pending-load=none.
- All ex_* bundle fields=0 and ex_aluop=0000.
REQ-024 Reset asserted mid-stall SHALL discard the stall; the first instruction after deassertion SHALL not stall.

Structure
REQ-025 ALU opcode codes, DLX opcode/func constants and the decoded-control struct SHALL live in package dlx_pkg.
REQ-026 The combinational decoder SHALL be sub-module dlx_decode_comb; dlx_decode_stage adds the pipeline register, interlock and redirect.

Verification
REQ-027 Verification SHALL cover these directed scenarios:
- addi r3,r1,#-4 (0x2023FFFC) -> next cycle ex_valid=1, aluop=0011, regwr=1, regdst=3, imm=0xFFFFFFFC, alusrc=0.
- lw r2,0(r1) then add r4,r2,r5 with LOAD_LAT=2 -> id_ready=0 for 2 cycles, two bubbles, then add issues with aluop=0011.
- beqz r1,+8 at pc 0x100, rs1_val=0 -> redirect_valid=1, redirect_pc=0x10C; rs1_val=5 -> no redirect.
- ex_ready=0 for 3 cycles with a bundle held -> ex_* fields unchanged, id_ready=0; release -> next instruction accepted.
- Opcode 0x3F -> ex_illegal=1, regwr=0, memwr=0.
- rst_n low during a stall -> ex_valid=0 immediately; after release, add r4,r2,r5 issues without stall.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: ALU operation codes, opcode/func
// constants, control-flow kinds and the decoded-control bundles passed
// from the combinational decoder to the decode-stage pipeline register.
package dlx_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADDU = 4'b0010,
        ALU_ADD  = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SUBU = 4'b0111,
        ALU_SLL  = 4'b1001,
        ALU_XOR  = 4'b1011
    } alu_op_e;

    // Primary opcodes (instr[0:5])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDUI   = 6'h09;
    localparam logic [5:0] OP_SUBI    = 6'h0A;
    localparam logic [5:0] OP_SUBUI   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LHI     = 6'h0F;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // R-type func codes (instr[26:31])
    localparam logic [5:0] FN_NOP  = 6'h15;
    localparam logic [5:0] FN_SUB  = 6'h18;
    localparam logic [5:0] FN_SUBU = 6'h19;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h28;

    typedef enum logic [2:0] {
        CF_NONE = 3'd0,
        CF_BEQZ = 3'd1,
        CF_BNEZ = 3'd2,
        CF_JUMP = 3'd3,   // j / jal: pc-relative 26-bit offset
        CF_JREG = 3'd4    // jr / jalr: target from rs1
    } cf_kind_e;

    // Fields that travel to EX through the pipeline register
    typedef struct packed {
        logic       regwr;
        logic [4:0] regdst;
        logic       extop;
        logic       alusrc;
        alu_op_e    aluop;
        logic       memwr;
        logic       memtoreg;
        logic       illegal;
    } ex_bundle_t;

    // Full decoder result: EX bundle plus interlock/redirect information
    typedef struct packed {
        ex_bundle_t ex;
        logic       is_load;
        cf_kind_e   cf;
        logic       uses_rs1;
        logic       uses_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_ctrl_t;

    // True when the decoded instruction sources register r
    function automatic logic reads_reg(dec_ctrl_t c, logic [4:0] r);
        return (c.uses_rs1 && (c.rs1 == r)) || (c.uses_rs2 && (c.rs2 == r));
    endfunction

endpackage

// File: rtl/dlx_decode_stage_if.sv
// Bundle of the decode-stage handshake and bus signals.
//   master : upstream fetch / downstream EX side (drives id_*, rs1_val, ex_ready)
//   slave  : the decode stage itself
interface dlx_decode_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [0:31]     id_instr;
    logic [PC_W-1:0] id_pc;
    logic [XLEN-1:0] rs1_val;
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_regwr;
    logic [4:0]      ex_regdst;
    logic            ex_extop;
    logic            ex_alusrc;
    logic [3:0]      ex_aluop;
    logic            ex_memwr;
    logic            ex_memtoreg;
    logic [XLEN-1:0] ex_imm;
    logic            ex_illegal;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output id_valid, id_instr, id_pc, rs1_val, ex_ready,
        input  id_ready, ex_valid, ex_regwr, ex_regdst, ex_extop, ex_alusrc,
               ex_aluop, ex_memwr, ex_memtoreg, ex_imm, ex_illegal,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  id_valid, id_instr, id_pc, rs1_val, ex_ready,
        output id_ready, ex_valid, ex_regwr, ex_regdst, ex_extop, ex_alusrc,
               ex_aluop, ex_memwr, ex_memtoreg, ex_imm, ex_illegal,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/dlx_decode_comb.sv
// Purely combinational DLX instruction decoder.
//   instr_i [0:31] : instruction, bit 0 is the MSB
//   ctrl_o         : decoded control (EX bundle, load/control-flow kind,
//                    source-register usage)
//   imm_o          : instr[16:31] sign- or zero-extended to XLEN
module dlx_decode_comb
    import dlx_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [0:31]     instr_i,
    output dec_ctrl_t       ctrl_o,
    output logic [XLEN-1:0] imm_o
);

    logic [5:0] opcode;
    logic [5:0] func;
    logic [4:0] rd_i;
    logic [4:0] rd_r;
    logic       unused_shamt;

    assign opcode       = instr_i[0:5];
    assign func         = instr_i[26:31];
    assign rd_i         = instr_i[11:15];
    assign rd_r         = instr_i[16:20];
    assign unused_shamt = ^instr_i[21:25];

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.ex.aluop  = ALU_AND;
        ctrl_o.rs1       = instr_i[6:10];
        ctrl_o.rs2       = instr_i[11:15];
        ctrl_o.ex.regdst = rd_i;
        ctrl_o.cf        = CF_NONE;

        unique case (opcode)
            OP_SPECIAL: begin
                ctrl_o.ex.regdst = rd_r;
                ctrl_o.ex.alusrc = 1'b1;
                ctrl_o.ex.regwr  = 1'b1;
                ctrl_o.uses_rs1  = 1'b1;
                ctrl_o.uses_rs2  = 1'b1;
                unique case (func)
                    FN_ADD:  ctrl_o.ex.aluop = ALU_ADD;
                    FN_ADDU: ctrl_o.ex.aluop = ALU_ADDU;
                    FN_SUB:  ctrl_o.ex.aluop = ALU_SUB;
                    FN_SUBU: ctrl_o.ex.aluop = ALU_SUBU;
                    FN_XOR:  ctrl_o.ex.aluop = ALU_XOR;
                    FN_SLT:  ctrl_o.ex.aluop = ALU_SLT;
                    FN_NOP: begin
                        ctrl_o.ex.regwr = 1'b0;
                        ctrl_o.uses_rs1 = 1'b0;
                        ctrl_o.uses_rs2 = 1'b0;
                    end
                    default: ctrl_o.ex.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_SUBI: begin
                ctrl_o.ex.aluop = (opcode == OP_ADDI) ? ALU_ADD : ALU_SUB;
                ctrl_o.ex.extop = 1'b1;
                ctrl_o.ex.regwr = 1'b1;
                ctrl_o.uses_rs1 = 1'b1;
            end
            OP_ADDUI, OP_SUBUI: begin
                ctrl_o.ex.aluop = (opcode == OP_ADDUI) ? ALU_ADDU : ALU_SUBU;
                ctrl_o.ex.regwr = 1'b1;
                ctrl_o.uses_rs1 = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.ex.aluop = (opcode == OP_ANDI) ? ALU_AND :
                                  (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                ctrl_o.ex.regwr = 1'b1;
                ctrl_o.uses_rs1 = 1'b1;
            end
            OP_LHI: begin
                // immediate shifted into the upper half; no register source
                ctrl_o.ex.aluop = ALU_SLL;
                ctrl_o.ex.regwr = 1'b1;
            end
            OP_LB, OP_LW, OP_LBU: begin
                ctrl_o.ex.aluop    = ALU_ADD;
                ctrl_o.ex.extop    = 1'b1;
                ctrl_o.ex.regwr    = 1'b1;
                ctrl_o.ex.memtoreg = 1'b1;
                ctrl_o.is_load     = 1'b1;
                ctrl_o.uses_rs1    = 1'b1;
            end
            OP_SB, OP_SW: begin
                // store data register sits in the I-type rd field
                ctrl_o.ex.aluop = ALU_ADD;
                ctrl_o.ex.extop = 1'b1;
                ctrl_o.ex.memwr = 1'b1;
                ctrl_o.uses_rs1 = 1'b1;
                ctrl_o.uses_rs2 = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
                ctrl_o.ex.extop = 1'b1;
                ctrl_o.uses_rs1 = 1'b1;
                ctrl_o.cf       = (opcode == OP_BEQZ) ? CF_BEQZ : CF_BNEZ;
            end
            OP_J: ctrl_o.cf = CF_JUMP;
            OP_JAL: begin
                ctrl_o.cf        = CF_JUMP;
                ctrl_o.ex.regwr  = 1'b1;
                ctrl_o.ex.regdst = 5'd31;
            end
            OP_JR: begin
                ctrl_o.cf       = CF_JREG;
                ctrl_o.uses_rs1 = 1'b1;
            end
            OP_JALR: begin
                ctrl_o.cf        = CF_JREG;
                ctrl_o.uses_rs1  = 1'b1;
                ctrl_o.ex.regwr  = 1'b1;
                ctrl_o.ex.regdst = 5'd31;
            end
            default: ctrl_o.ex.illegal = 1'b1;
        endcase

        // An illegal instruction must have no architectural side effect
        if (ctrl_o.ex.illegal) begin
            ctrl_o.ex.regwr    = 1'b0;
            ctrl_o.ex.memwr    = 1'b0;
            ctrl_o.ex.memtoreg = 1'b0;
            ctrl_o.is_load     = 1'b0;
            ctrl_o.cf          = CF_NONE;
            ctrl_o.uses_rs1    = 1'b0;
            ctrl_o.uses_rs2    = 1'b0;
        end
    end

    assign imm_o = ctrl_o.ex.extop ? {{(XLEN-16){instr_i[16]}}, instr_i[16:31]}
                                   : {{(XLEN-16){1'b0}},        instr_i[16:31]};

endmodule

// File: rtl/dlx_decode_stage.sv
// DLX decode pipeline stage: decodes the instruction at id_instr, registers
// the control bundle toward EX with a valid/ready handshake, inserts
// load-use bubbles and raises a one-cycle redirect for taken control flow.
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_valid/id_ready   : instruction handshake from fetch
//   id_instr, id_pc     : instruction (bit 0 = MSB) and its PC
//   rs1_val             : register-file read of rs1
//   ex_valid/ex_ready   : decoded-bundle handshake toward EX
//   ex_*                : registered decode bundle
//   redirect_valid/_pc  : combinational taken-branch/jump pulse and target
module dlx_decode_stage
    import dlx_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [0:31]     id_instr,
    input  logic [PC_W-1:0] id_pc,
    input  logic [XLEN-1:0] rs1_val,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic            ex_regwr,
    output logic [4:0]      ex_regdst,
    output logic            ex_extop,
    output logic            ex_alusrc,
    output logic [3:0]      ex_aluop,
    output logic            ex_memwr,
    output logic            ex_memtoreg,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_illegal,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc
);

    dec_ctrl_t       dec;
    logic [XLEN-1:0] dec_imm;

    dlx_decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr_i (id_instr),
        .ctrl_o  (dec),
        .imm_o   (dec_imm)
    );

    logic            ex_valid_q;
    ex_bundle_t      ex_q;
    logic [XLEN-1:0] ex_imm_q;
    logic [1:0]      ldcnt_q, ldcnt_d;
    logic [4:0]      ldrd_q, ldrd_d;
    logic            stall;
    logic            out_load;
    logic            accept;

    // Pending-load counter doubles as the stall counter: it is armed when a
    // load is accepted and ages on every cycle the output register loads
    // (an issue or a bubble), so an instruction that arrives after LOAD_LAT
    // such cycles no longer sees the hazard.
    assign stall    = (ldcnt_q != 2'd0) && reads_reg(dec, ldrd_q);
    assign out_load = !ex_valid_q || ex_ready;
    assign id_ready = rst_n && out_load && !stall;
    assign accept   = id_valid && id_ready;

    always_comb begin
        ldcnt_d = ldcnt_q;
        ldrd_d  = ldrd_q;
        if (accept && dec.is_load && (dec.ex.regdst != 5'd0)) begin
            ldcnt_d = 2'(LOAD_LAT);
            ldrd_d  = dec.ex.regdst;
        end else if (out_load && (ldcnt_q != 2'd0)) begin
            ldcnt_d = ldcnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            ex_imm_q   <= '0;
            ldcnt_q    <= '0;
            ldrd_q     <= '0;
        end else begin
            ldcnt_q <= ldcnt_d;
            ldrd_q  <= ldrd_d;
            if (out_load) begin
                ex_valid_q <= accept;
                if (accept) begin
                    ex_q     <= dec.ex;
                    ex_imm_q <= dec_imm;
                end
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regwr    = ex_q.regwr;
    assign ex_regdst   = ex_q.regdst;
    assign ex_extop    = ex_q.extop;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_aluop    = ex_q.aluop;
    assign ex_memwr    = ex_q.memwr;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_imm      = ex_imm_q;
    assign ex_illegal  = ex_q.illegal;

    // Redirect targets; additions wrap modulo 2^PC_W
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] j_off;
    logic            rs1_zero;
    logic            taken;

    assign pc_plus4 = id_pc + PC_W'(4);
    assign br_off   = {{(PC_W-16){id_instr[16]}}, id_instr[16:31]};
    assign j_off    = {{(PC_W-26){id_instr[6]}},  id_instr[6:31]};
    assign rs1_zero = (rs1_val == '0);

    always_comb begin
        taken       = 1'b0;
        redirect_pc = pc_plus4 + br_off;
        unique case (dec.cf)
            CF_BEQZ: taken = rs1_zero;
            CF_BNEZ: taken = !rs1_zero;
            CF_JUMP: begin
                taken       = 1'b1;
                redirect_pc = pc_plus4 + j_off;
            end
            CF_JREG: begin
                taken       = 1'b1;
                redirect_pc = PC_W'(rs1_val);
            end
            default: taken = 1'b0;
        endcase
    end

    assign redirect_valid = accept && taken;

endmodule

// File: tb/tb_dlx_decode_stage.sv
module tb_dlx_decode_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dlx_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

    dlx_decode_stage #(.XLEN(32), .LOAD_LAT(2), .PC_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (bus.id_valid),
        .id_ready       (bus.id_ready),
        .id_instr       (bus.id_instr),
        .id_pc          (bus.id_pc),
        .rs1_val        (bus.rs1_val),
        .ex_valid       (bus.ex_valid),
        .ex_ready       (bus.ex_ready),
        .ex_regwr       (bus.ex_regwr),
        .ex_regdst      (bus.ex_regdst),
        .ex_extop       (bus.ex_extop),
        .ex_alusrc      (bus.ex_alusrc),
        .ex_aluop       (bus.ex_aluop),
        .ex_memwr       (bus.ex_memwr),
        .ex_memtoreg    (bus.ex_memtoreg),
        .ex_imm         (bus.ex_imm),
        .ex_illegal     (bus.ex_illegal),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI = 32'h2023FFFC; // addi r3,r1,#-4
    localparam logic [31:0] I_LW   = 32'h8C220000; // lw   r2,0(r1)
    localparam logic [31:0] I_ADD  = 32'h00452020; // add  r4,r2,r5
    localparam logic [31:0] I_BEQZ = 32'h10200008; // beqz r1,+8
    localparam logic [31:0] I_BNEZ = 32'h14200010; // bnez r1,+16
    localparam logic [31:0] I_JR   = 32'h48600000; // jr   r3
    localparam logic [31:0] I_J    = 32'h0BFFFFFC; // j    -4
    localparam logic [31:0] I_ORI  = 32'h34078000; // ori  r7,r0,#0x8000
    localparam logic [31:0] I_SW   = 32'hAC250004; // sw   r5,4(r1)
    localparam logic [31:0] I_NOP  = 32'h00000015; // nop
    localparam logic [31:0] I_BAD  = 32'hFC220000; // opcode 0x3F

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] ins,
                           input logic [31:0] pc, input logic [31:0] rs1);
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.id_pc    = pc;
        bus.rs1_val  = rs1;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ex_ready = 1'b1;
        present(1'b0, 32'h0, 32'h0, 32'h0);

        // reset state
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_redirect", bus.redirect_valid, 0);
        chk("rst_aluop", bus.ex_aluop, 0);
        chk("rst_regwr", bus.ex_regwr, 0);
        chk("rst_imm", bus.ex_imm, 0);
        #10;
        rst_n = 1'b1;

        // addi r3,r1,#-4
        present(1'b1, I_ADDI, 32'h0, 32'h1);
        chk("addi_ready", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;
        chk("addi_valid", bus.ex_valid, 1);
        chk("addi_aluop", bus.ex_aluop, 4'b0011);
        chk("addi_regwr", bus.ex_regwr, 1);
        chk("addi_regdst", bus.ex_regdst, 3);
        chk("addi_imm", bus.ex_imm, 32'hFFFFFFFC);
        chk("addi_alusrc", bus.ex_alusrc, 0);
        chk("addi_extop", bus.ex_extop, 1);

        // lw r2 then dependent add: two stall cycles, two bubbles
        present(1'b1, I_LW, 32'h4, 32'h0);
        chk("lw_ready", bus.id_ready, 1);
        tick();
        chk("lw_memtoreg", bus.ex_memtoreg, 1);
        chk("lw_regdst", bus.ex_regdst, 2);
        present(1'b1, I_ADD, 32'h8, 32'h0);
        chk("lu_stall1", bus.id_ready, 0);
        tick();
        chk("lu_bubble1", bus.ex_valid, 0);
        chk("lu_stall2", bus.id_ready, 0);
        tick();
        chk("lu_bubble2", bus.ex_valid, 0);
        chk("lu_release", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;
        chk("add_valid", bus.ex_valid, 1);
        chk("add_aluop", bus.ex_aluop, 4'b0011);
        chk("add_regdst", bus.ex_regdst, 4);
        chk("add_alusrc", bus.ex_alusrc, 1);

        // beqz r1,+8 at 0x100
        present(1'b1, I_BEQZ, 32'h100, 32'h0);
        chk("beqz_taken", bus.redirect_valid, 1);
        chk("beqz_pc", bus.redirect_pc, 32'h10C);
        tick();
        chk("beqz_regwr", bus.ex_regwr, 0);
        present(1'b1, I_BEQZ, 32'h100, 32'h5);
        chk("beqz_not_taken", bus.redirect_valid, 0);
        tick();

        // bnez with target wrap, jr, j
        present(1'b1, I_BNEZ, 32'hFFFFFFF8, 32'h7);
        chk("bnez_taken", bus.redirect_valid, 1);
        chk("bnez_wrap_pc", bus.redirect_pc, 32'h0000000C);
        tick();
        present(1'b1, I_JR, 32'h40, 32'h1234);
        chk("jr_taken", bus.redirect_valid, 1);
        chk("jr_pc", bus.redirect_pc, 32'h1234);
        tick();
        chk("jr_regwr", bus.ex_regwr, 0);
        present(1'b1, I_J, 32'h200, 32'h0);
        chk("j_pc", bus.redirect_pc, 32'h200);
        tick();

        // EX backpressure holds bundle
        present(1'b1, I_ORI, 32'h300, 32'h0);
        tick();
        bus.ex_ready = 1'b0;
        present(1'b1, I_ADDI, 32'h304, 32'h0);
        chk("hold_ready0", bus.id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", bus.ex_valid, 1);
            chk("hold_imm", bus.ex_imm, 32'h00008000);
            chk("hold_aluop", bus.ex_aluop, 4'b0001);
            chk("hold_regdst", bus.ex_regdst, 7);
            chk("hold_ready", bus.id_ready, 0);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("release_ready", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;
        chk("release_imm", bus.ex_imm, 32'hFFFFFFFC);
        chk("release_regdst", bus.ex_regdst, 3);

        // store, nop, illegal
        present(1'b1, I_SW, 32'h400, 32'h0);
        tick();
        chk("sw_memwr", bus.ex_memwr, 1);
        chk("sw_regwr", bus.ex_regwr, 0);
        present(1'b1, I_NOP, 32'h404, 32'h0);
        tick();
        chk("nop_regwr", bus.ex_regwr, 0);
        chk("nop_illegal", bus.ex_illegal, 0);
        present(1'b1, I_BAD, 32'h408, 32'h0);
        chk("bad_redirect", bus.redirect_valid, 0);
        tick();
        chk("bad_illegal", bus.ex_illegal, 1);
        chk("bad_regwr", bus.ex_regwr, 0);
        chk("bad_memwr", bus.ex_memwr, 0);

        // load ages past two intervening issues: no stall
        present(1'b1, I_LW, 32'h500, 32'h0);
        tick();
        present(1'b1, I_ORI, 32'h504, 32'h0);
        tick();
        present(1'b1, I_ORI, 32'h508, 32'h0);
        tick();
        present(1'b1, I_ADD, 32'h50C, 32'h0);
        chk("aged_no_stall", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;

        // reset during a stall
        present(1'b1, I_LW, 32'h600, 32'h0);
        tick();
        present(1'b1, I_ADD, 32'h604, 32'h0);
        chk("pre_rst_stall", bus.id_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.ex_valid, 0);
        tick();
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;
        chk("post_rst_valid", bus.ex_valid, 1);
        chk("post_rst_aluop", bus.ex_aluop, 4'b0011);
        chk("post_rst_regdst", bus.ex_regdst, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
